spi_ram_arbiter: RTL and testbench
==================================

# spi_ram_arbiter

Two-master arbiter and command sequencer for the single-port RAM's 10-bit command interface. It accepts complete read/write transactions from two requesters, for example the SPI slave path and a local host/DMA port, and grants them round-robin. Each transaction is serialized into the RAM's two-command opcode sequence, and read data is returned from the RAM's `tx_valid`/`dout` response. It sits between the requesters and the RAM instance, in place of a direct SPI-to-RAM connection.

## Interface
- `ADDR_SIZE`, 8: address width; must match the RAM.
- `RD_TIMEOUT`, 4: maximum cycles to wait for RAM `tx_valid` on a read; range 1..15.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `m0_req` in 1: master 0 transaction request; held until `m0_ack`.
- `m0_we` in 1: 1 = write, 0 = read.
- `m0_addr` in `ADDR_SIZE`: transaction address.
- `m0_wdata` in 8: write data.
- `m0_ack` out 1: one-cycle completion pulse.
- `m0_rdata` out 8: read data; valid in the `m0_ack` cycle.
- `m0_err` out 1: read timeout flag; valid in the `m0_ack` cycle.
- `m1_*`: same set as `m0_*`, for master 1.
- `ram_din` out 10: RAM command word, {opcode[1:0], payload[7:0]}.
- `ram_rx_valid` out 1: command strobe to the RAM.
- `ram_dout` in 8: RAM read data.
- `ram_tx_valid` in 1: RAM read-data strobe.
- `busy` out 1: high in any state other than IDLE.

## Operation
- RAM opcodes: 00 = write address, 01 = write data, 10 = read address, 11 = read data (payload ignored; driven 0).
- FSM states:
  - IDLE: arbitrate the requests. On a grant, latch we/addr/wdata and the owner, then go to ADDR.
  - ADDR: drive {00 or 10, addr} with `rx_valid`=1. Go to DATA on a write, RCMD on a read.
  - DATA: drive {01, wdata} with `rx_valid`=1. Go to DONE.
  - RCMD: drive {11, 8'h00} with `rx_valid`=1. Go to WAIT.
  - WAIT: `rx_valid`=0, count cycles.
    - On `ram_tx_valid`: capture `ram_dout`, go to DONE with err=0.
    - After `RD_TIMEOUT` cycles without it: go to DONE with err=1 and rdata=0.
  - DONE: pulse the owner's ack, then go to IDLE.
- Arbitration:
  - Round-robin over two masters, tracked by a last-grant pointer.
  - When only one master requests, it wins.
  - When both request, the master not granted last wins.
  - The pointer resets to "m1 last", so m0 wins the first contention.
- In the cycle after its ack, the acked master's `req` is ignored in IDLE. This gives the requester one cycle to drop `req`; the other master may be granted in that cycle.
- Request fields are latched at grant. Later changes, or `req` dropping mid-transaction, do not affect the in-flight transaction.
- `ram_rx_valid` is never asserted outside ADDR, DATA and RCMD. `ram_din` is 0 whenever `rx_valid` is 0.
- `ram_tx_valid` outside WAIT is ignored.
- `mX_rdata` and `mX_err` are registered. They are updated only in the owner's ack cycle and hold their values until the next ack to the same master.

## Timing
- Reset: all outputs are 0 and the FSM is in IDLE. A reset during a transaction aborts it with no ack. The RAM's internally latched address is not cleared.
- Cycle numbering is relative to the edge at which `req` is sampled high in IDLE, which is cycle 0.
- Write:
  - Cycle 1: ADDR.
  - Cycle 2: DATA.
  - Cycle 3: DONE, ack=1.
  - Latency is 3 cycles and a new grant is possible at cycle 4.
- Read:
  - Cycle 1: ADDR.
  - Cycle 2: RCMD.
  - Cycle 3: WAIT. A RAM with 1-cycle latency asserts `tx_valid` here.
  - Cycle 4: ack with rdata.
  - Nominal latency is 4 cycles.
- Read timeout: ack at cycle 3 + `RD_TIMEOUT` with err=1.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Package `spi_ram_arb_pkg` holds:
  - the state enum (IDLE, ADDR, DATA, RCMD, WAIT, DONE);
  - opcode constants `OP_WR_ADDR`, `OP_WR_DATA`, `OP_RD_ADDR`, `OP_RD_DATA`;
  - the command width constant 10.
- Sub-module `rr_arb2`: a two-request round-robin arbiter. It has a last-grant register, and inputs `req[1:0]`, `mask[1:0]` and `advance`; it outputs a one-hot `gnt[1:0]`.

## Test plan
- m0 writes addr 8'h3C, data 8'hA5:
  - `ram_din` = 10'h03C in cycle 1 and 10'h1A5 in cycle 2.
  - `m0_ack` pulses in cycle 3; `busy` is high in cycles 1-3.
- m1 reads addr 8'h3C with the RAM model returning 8'hA5 one cycle after the 11-command:
  - `ram_din` = 10'h23C then 10'h300.
  - `m1_ack`=1, `m1_rdata`=8'hA5, `m1_err`=0 at cycle 4.
- m0 and m1 both request continuously, and each drops `req` after its ack and re-raises it:
  - Grants go m0, m1, m0, m1.
  - There are no back-to-back grants to the same master while the other is requesting.
- Read with RAM `tx_valid` suppressed and `RD_TIMEOUT`=4:
  - ack at cycle 7 with err=1 and rdata=8'h00.
  - The next transaction proceeds normally.
- `rst_n` is asserted low at cycle 2 of a write (DATA):
  - The next cycle shows `rx_valid`=0, `busy`=0 and no ack.
  - A fresh request afterward completes normally.
- A stray `ram_tx_valid` pulse during a write, or a change in `m0_addr` after grant:
  - Neither has any effect on `ram_din` or on the returned data.

Source files
------------

// File: rtl/spi_ram_arb_pkg.sv
// Shared types and constants for the SPI RAM arbiter.
// - state_t : sequencer states (IDLE, ADDR, DATA, RCMD, WAIT, DONE)
// - OP_*    : RAM command opcodes, placed in the top two bits of the command word
// - CMD_W   : RAM command word width
// - make_cmd: packs an opcode and an 8-bit payload into one command word
package spi_ram_arb_pkg;

  localparam int CMD_W = 10;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    DATA = 3'd2,
    RCMD = 3'd3,
    WAIT = 3'd4,
    DONE = 3'd5
  } state_t;

  function automatic logic [CMD_W-1:0] make_cmd(input logic [1:0] op, input logic [7:0] payload);
    return {op, payload};
  endfunction

endpackage

// File: rtl/spi_ram_arbiter_rr_arb2.sv
// Two-request round-robin arbiter.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   req[1:0]    : request lines
//   mask[1:0]   : requests to ignore this cycle
//   advance     : a grant is being taken; remember who won
//   gnt[1:0]    : one-hot grant (combinational from req/mask/last-grant)
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       advance,
  output logic [1:0] gnt
);

  // 1 = master 1 was granted last. Resets to 1 so master 0 wins the first tie.
  logic       r_last;
  logic [1:0] w_eligible;

  always_comb begin
    w_eligible = req & ~mask;
    gnt        = w_eligible;
    if (w_eligible == 2'b11) begin
      gnt = r_last ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (advance && (gnt != 2'b00)) begin
      r_last <= gnt[1];
    end
  end

endmodule

// File: rtl/spi_ram_arbiter.sv
// Two-master arbiter and command sequencer for a single-port RAM with a
// 10-bit command interface. Each granted transaction becomes an address
// command followed by a data (write) or read-data (read) command; read data
// comes back on ram_tx_valid/ram_dout, bounded by RD_TIMEOUT cycles.
// Ports:
//   clk, rst_n                         : clock, synchronous active-low reset
//   mX_req/we/addr/wdata               : master X request (held until ack)
//   mX_ack/rdata/err                   : master X completion pulse and read result
//   ram_din, ram_rx_valid              : command word and strobe to the RAM
//   ram_dout, ram_tx_valid             : read data and strobe from the RAM
//   busy                               : sequencer not idle
// Every output is a register; command/ack values are computed from the next
// state so they line up with the state they belong to.
module spi_ram_arbiter
  import spi_ram_arb_pkg::*;
#(
  parameter int ADDR_SIZE  = 8,
  parameter int RD_TIMEOUT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 m0_req,
  input  logic                 m0_we,
  input  logic [ADDR_SIZE-1:0] m0_addr,
  input  logic [7:0]           m0_wdata,
  output logic                 m0_ack,
  output logic [7:0]           m0_rdata,
  output logic                 m0_err,
  input  logic                 m1_req,
  input  logic                 m1_we,
  input  logic [ADDR_SIZE-1:0] m1_addr,
  input  logic [7:0]           m1_wdata,
  output logic                 m1_ack,
  output logic [7:0]           m1_rdata,
  output logic                 m1_err,
  output logic [CMD_W-1:0]     ram_din,
  output logic                 ram_rx_valid,
  input  logic [7:0]           ram_dout,
  input  logic                 ram_tx_valid,
  output logic                 busy
);

  localparam logic [3:0] TO_LAST = 4'(RD_TIMEOUT - 1);

  state_t                 r_state, w_state_next;
  logic                   r_we, r_owner;
  logic [ADDR_SIZE-1:0]   r_addr;
  logic [7:0]             r_wdata;
  logic [3:0]             r_cnt, w_cnt_next;
  logic [1:0]             r_mask;
  logic [CMD_W-1:0]       r_ram_din, w_cmd_next;
  logic                   r_rx_valid, w_rx_valid_next;
  logic                   r_busy, r_m0_ack, r_m1_ack, r_m0_err, r_m1_err;
  logic [7:0]             r_m0_rdata, r_m1_rdata;
  logic [1:0]             w_gnt;
  logic                   w_sel_we, w_ack_next, w_res_err;
  logic [ADDR_SIZE-1:0]   w_sel_addr;
  logic [7:0]             w_sel_wdata, w_res_data;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({m1_req, m0_req}),
    .mask    (r_mask),
    .advance (r_state == IDLE),
    .gnt     (w_gnt)
  );

  assign w_sel_we    = w_gnt[1] ? m1_we    : m0_we;
  assign w_sel_addr  = w_gnt[1] ? m1_addr  : m0_addr;
  assign w_sel_wdata = w_gnt[1] ? m1_wdata : m0_wdata;

  always_comb begin
    w_state_next    = r_state;
    w_cmd_next      = '0;
    w_rx_valid_next = 1'b0;
    w_cnt_next      = r_cnt;
    w_res_data      = 8'h00;
    w_res_err       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_gnt != 2'b00) begin
          w_state_next    = ADDR;
          w_rx_valid_next = 1'b1;
          w_cmd_next      = make_cmd(w_sel_we ? OP_WR_ADDR : OP_RD_ADDR, 8'(w_sel_addr));
        end
      end
      ADDR: begin
        w_rx_valid_next = 1'b1;
        if (r_we) begin
          w_state_next = DATA;
          w_cmd_next   = make_cmd(OP_WR_DATA, r_wdata);
        end else begin
          w_state_next = RCMD;
          w_cmd_next   = make_cmd(OP_RD_DATA, 8'h00);
        end
      end
      DATA: w_state_next = DONE;
      RCMD: begin
        w_state_next = WAIT;
        w_cnt_next   = 4'd0;
      end
      WAIT: begin
        // A response in the last allowed cycle still wins over the timeout.
        if (ram_tx_valid) begin
          w_state_next = DONE;
          w_res_data   = ram_dout;
        end else if (r_cnt == TO_LAST) begin
          w_state_next = DONE;
          w_res_err    = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 4'd1;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign w_ack_next = (w_state_next == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_we       <= 1'b0;
      r_owner    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= 8'h00;
      r_cnt      <= 4'd0;
      r_mask     <= 2'b00;
      r_ram_din  <= '0;
      r_rx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_m0_ack   <= 1'b0;
      r_m1_ack   <= 1'b0;
      r_m0_err   <= 1'b0;
      r_m1_err   <= 1'b0;
      r_m0_rdata <= 8'h00;
      r_m1_rdata <= 8'h00;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_ram_din  <= w_cmd_next;
      r_rx_valid <= w_rx_valid_next;
      r_busy     <= (w_state_next != IDLE);
      r_m0_ack   <= w_ack_next && !r_owner;
      r_m1_ack   <= w_ack_next && r_owner;
      // The just-acked master is ignored for one IDLE cycle so it can drop req.
      r_mask     <= (r_state == DONE) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
      if ((r_state == IDLE) && (w_gnt != 2'b00)) begin
        r_we    <= w_sel_we;
        r_owner <= w_gnt[1];
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_wdata;
      end
      // Read data only changes on a read ack; err is cleared by any ack.
      if (w_ack_next) begin
        if (r_owner) begin
          r_m1_err <= w_res_err;
          if (!r_we) r_m1_rdata <= w_res_data;
        end else begin
          r_m0_err <= w_res_err;
          if (!r_we) r_m0_rdata <= w_res_data;
        end
      end
    end
  end

  assign ram_din      = r_ram_din;
  assign ram_rx_valid = r_rx_valid;
  assign busy         = r_busy;
  assign m0_ack       = r_m0_ack;
  assign m1_ack       = r_m1_ack;
  assign m0_rdata     = r_m0_rdata;
  assign m1_rdata     = r_m1_rdata;
  assign m0_err       = r_m0_err;
  assign m1_err       = r_m1_err;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Bench for spi_ram_arbiter: directed cycle-exact transactions, arbitration
// order checks and a randomized two-master phase. Expected read data comes
// from a golden byte array updated as writes complete.
module tb_spi_ram_arbiter;
  localparam int TB_RD_TIMEOUT = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       m0_req, m0_we, m1_req, m1_we;
  logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic       m0_ack, m0_err, m1_ack, m1_err;
  logic [7:0] m0_rdata, m1_rdata;
  logic [9:0] ram_din;
  logic       ram_rx_valid, ram_tx_valid, busy;
  logic [7:0] ram_dout;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] gold [256];
  int         ack_log [$];

  // Simple 1-cycle-latency RAM with a response suppressor and a stray-strobe injector.
  logic [7:0] ram_mem [256];
  logic [7:0] ram_addr_q, ram_dout_q;
  logic       ram_tv_q = 1'b0;
  logic       ram_stray = 1'b0, ram_suppress = 1'b0;

  always #5 clk = ~clk;

  spi_ram_arbiter #(.ADDR_SIZE(8), .RD_TIMEOUT(TB_RD_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
    .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid), .busy(busy)
  );

  always @(posedge clk) begin
    ram_tv_q <= 1'b0;
    if (ram_rx_valid) begin
      case (ram_din[9:8])
        2'b00, 2'b10: ram_addr_q <= ram_din[7:0];
        2'b01:        ram_mem[ram_addr_q] <= ram_din[7:0];
        default: begin
          ram_tv_q   <= !ram_suppress;
          ram_dout_q <= ram_mem[ram_addr_q];
        end
      endcase
    end
  end
  assign ram_tx_valid = ram_tv_q | ram_stray;
  assign ram_dout     = ram_stray ? 8'hEE : ram_dout_q;

  always @(negedge clk) begin
    if (m0_ack) ack_log.push_back(0);
    if (m1_ack) ack_log.push_back(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int m, input logic req, input logic we,
                       input logic [7:0] addr, input logic [7:0] wdata);
    if (m == 0) begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    end else begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
    end
  endtask

  // Cycle-exact transaction from an idle DUT; called and returning at a negedge.
  task automatic run_txn(input int m, input logic we, input logic [7:0] addr,
                         input logic [7:0] wdata, input int lat,
                         input logic [7:0] exp_rdata, input logic exp_err, input bit disturb);
    logic [9:0] exp_din;
    logic       got_ack, other_ack;
    drive(m, 1'b1, we, addr, wdata);
    @(posedge clk);
    if (disturb) begin
      #1;
      drive(m, 1'b1, ~we, addr ^ 8'hFF, ~wdata);
    end
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      if (disturb) ram_stray = (k <= 2);
      if (k == 1)      exp_din = {(we ? 2'b00 : 2'b10), addr};
      else if (k == 2) exp_din = we ? {2'b01, wdata} : {2'b11, 8'h00};
      else             exp_din = 10'h000;
      got_ack   = (m == 0) ? m0_ack : m1_ack;
      other_ack = (m == 0) ? m1_ack : m0_ack;
      check_eq($sformatf("m%0d c%0d ram_din", m, k), 32'(ram_din), 32'(exp_din));
      check_eq($sformatf("m%0d c%0d rx_valid", m, k), 32'(ram_rx_valid), 32'(k <= 2));
      check_eq($sformatf("m%0d c%0d busy", m, k), 32'(busy), 32'(k <= lat));
      check_eq($sformatf("m%0d c%0d ack", m, k), 32'(got_ack), 32'(k == lat));
      check_eq($sformatf("m%0d c%0d other_ack", m, k), 32'(other_ack), 32'd0);
      if (k == lat) begin
        if (!we) begin
          check_eq($sformatf("m%0d rdata", m), 32'((m == 0) ? m0_rdata : m1_rdata), 32'(exp_rdata));
          check_eq($sformatf("m%0d err", m), 32'((m == 0) ? m0_err : m1_err), 32'(exp_err));
        end
        drive(m, 1'b0, we, addr, wdata);
      end
    end
    if (we) gold[addr] = wdata;
    $display("[TB] directed m%0d %s addr=%02h data=%02h", m, we ? "write" : "read", addr,
             we ? wdata : exp_rdata);
  endtask

  // Free-running master: n transactions, waits (bounded) for each ack.
  task automatic master_run(input int m, input int n, input bit rnd);
    logic       we, got, err_v;
    logic [7:0] addr, wdata, rd;
    for (int i = 0; i < n; i++) begin
      we    = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      addr  = rnd ? (8'h80 | 8'($urandom_range(0, 127))) : 8'(8'h20 + m);
      wdata = 8'($urandom_range(0, 255));
      drive(m, 1'b1, we, addr, wdata);
      got = 1'b0;
      for (int t = 0; t < 60 && !got; t++) begin
        @(negedge clk);
        got = (m == 0) ? m0_ack : m1_ack;
      end
      check_eq($sformatf("m%0d ack seen", m), 32'(got), 32'd1);
      if (got) begin
        rd    = (m == 0) ? m0_rdata : m1_rdata;
        err_v = (m == 0) ? m0_err : m1_err;
        if (we) begin
          gold[addr] = wdata;
        end else begin
          check_eq($sformatf("m%0d rnd rdata @%02h", m, addr), 32'(rd), 32'(gold[addr]));
          check_eq($sformatf("m%0d rnd err", m), 32'(err_v), 32'd0);
        end
      end
      $display("[TB] m%0d %s addr=%02h data=%02h", m, we ? "write" : "read", addr, we ? wdata : rd);
      drive(m, 1'b0, we, addr, wdata);
      repeat (rnd ? $urandom_range(1, 3) : 1) @(negedge clk);
    end
  endtask

  task automatic check_log(input string tag, input int first, input int len);
    check_eq({tag, " count"}, 32'(ack_log.size()), 32'(len));
    for (int i = 0; i < len && i < ack_log.size(); i++)
      check_eq($sformatf("%s order %0d", tag, i), 32'(ack_log[i]), 32'((first + i) % 2));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = 8'h00;
      gold[i]    = 8'h00;
    end
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset ram_din", 32'(ram_din), 32'd0);
    check_eq("reset rx_valid", 32'(ram_rx_valid), 32'd0);
    check_eq("reset busy", 32'(busy), 32'd0);
    check_eq("reset acks", 32'({m0_ack, m1_ack}), 32'd0);
    check_eq("reset rdata", 32'({m0_rdata, m1_rdata}), 32'd0);
    check_eq("reset err", 32'({m0_err, m1_err}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic write then read with 1-cycle RAM response.
    run_txn(0, 1'b1, 8'h3C, 8'hA5, 3, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    run_txn(1, 1'b0, 8'h3C, 8'h00, 4, gold[8'h3C], 1'b0, 1'b0);
    @(negedge clk);

    // Read timeout, then a normal read; m1_rdata must still hold its value.
    ram_suppress = 1'b1;
    run_txn(0, 1'b0, 8'h3C, 8'h00, 3 + TB_RD_TIMEOUT, 8'h00, 1'b1, 1'b0);
    ram_suppress = 1'b0;
    @(negedge clk);
    run_txn(0, 1'b0, 8'h3C, 8'h00, 4, gold[8'h3C], 1'b0, 1'b0);
    check_eq("m1 rdata held", 32'(m1_rdata), 32'h0A5);

    // Reset in the DATA cycle of a write aborts with no ack.
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 8'h10, 8'h77);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b1, 8'h10, 8'h77);
    gold[8'h10] = 8'h77; // DATA command was already presented to the RAM
    @(negedge clk);
    check_eq("abort rx_valid", 32'(ram_rx_valid), 32'd0);
    check_eq("abort busy", 32'(busy), 32'd0);
    check_eq("abort ack", 32'(m0_ack), 32'd0);
    check_eq("abort ram_din", 32'(ram_din), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run_txn(0, 1'b1, 8'h10, 8'h5A, 3, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    run_txn(1, 1'b0, 8'h10, 8'h00, 4, gold[8'h10], 1'b0, 1'b0);

    // Field changes after grant and a stray tx_valid must not matter.
    @(negedge clk);
    run_txn(0, 1'b1, 8'h44, 8'h3E, 3, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    run_txn(1, 1'b0, 8'h44, 8'h00, 4, gold[8'h44], 1'b0, 1'b0);
    @(negedge clk);
    run_txn(1, 1'b0, 8'hBB, 8'h00, 4, gold[8'hBB], 1'b0, 1'b0);

    // Continuous contention after reset: m0, m1, m0, m1.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ack_log.delete();
    fork
      master_run(0, 2, 1'b0);
      master_run(1, 2, 1'b0);
    join
    check_log("contention", 0, 4);

    // Pointer: last grant was m1, so a fresh tie goes to m0.
    repeat (2) @(negedge clk);
    ack_log.delete();
    fork
      master_run(0, 1, 1'b0);
      master_run(1, 1, 1'b0);
    join
    check_log("tie after m1", 0, 2);

    // After a solo m0 grant, a fresh tie goes to m1.
    repeat (2) @(negedge clk);
    master_run(0, 1, 1'b0);
    repeat (2) @(negedge clk);
    ack_log.delete();
    fork
      master_run(0, 1, 1'b0);
      master_run(1, 1, 1'b0);
    join
    check_log("tie after m0", 1, 2);

    // Randomized traffic from both masters.
    repeat (2) @(negedge clk);
    fork
      master_run(0, 12, 1'b1);
      master_run(1, 12, 1'b1);
    join

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
